// File: rtl/m72_pkg.sv
// Shared types and constants for the m72 video fetch path.
package m72_pkg;

  localparam int GFX_ARB_NREQ = 3;

  typedef enum logic [1:0] {
    ARB_SYNC = 2'd0,
    ARB_IDLE = 2'd1,
    ARB_WAIT = 2'd2
  } gfx_arb_state_t;

endpackage

// File: rtl/gfx_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending requester after last_grant, wrapping.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] pending_i,
  input  logic [IW-1:0]   last_grant_i,
  output logic            any_o,
  output logic [IW-1:0]   grant_o
);

  int   idx;
  logic found;

  always_comb begin
    found   = 1'b0;
    grant_o = '0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_grant_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && pending_i[idx[IW-1:0]]) begin
        found   = 1'b1;
        grant_o = idx[IW-1:0];
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/gfx_rom_arbiter.sv
// Shares one SDRAM gfx-ROM read port between NREQ toggle-handshake requesters,
// with a one-word last-fetch cache per requester for single-cycle repeat hits.
module gfx_rom_arbiter
  import m72_pkg::*;
#(
  parameter int AW         = 24,
  parameter int DW         = 32,
  parameter int NREQ       = GFX_ARB_NREQ,
  parameter int HIT_BYPASS = 1
) (
  input  logic               CLK_96M,
  input  logic               reset_n,
  input  logic [NREQ*AW-1:0] rq_addr,
  input  logic [NREQ-1:0]    rq_req,
  output logic [NREQ-1:0]    rq_ack,
  output logic [NREQ*DW-1:0] rq_q,
  input  logic               inv,
  output logic [AW-1:0]      sdr_addr,
  output logic               sdr_req,
  input  logic               sdr_ack,
  input  logic [DW-1:0]      sdr_q
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  gfx_arb_state_t  state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic            sdr_req_q, sdr_req_d;
  logic [AW-1:0]   sdr_addr_q, sdr_addr_d;
  logic [NREQ-1:0] rq_ack_q, rq_ack_d;
  logic [NREQ-1:0] valid_q, valid_d;
  logic            drop_q, drop_d;
  logic [DW-1:0]   rq_q_q [NREQ];
  logic [DW-1:0]   rq_q_d [NREQ];
  logic [AW-1:0]   tag_q  [NREQ];
  logic [AW-1:0]   tag_d  [NREQ];
  logic [DW-1:0]   data_q [NREQ];
  logic [DW-1:0]   data_d [NREQ];
  logic [AW-1:0]   addr_a [NREQ];

  logic [NREQ-1:0] pending;
  logic            pick_any;
  logic [IW-1:0]   pick_g;
  logic            hit;
  logic            sdr_done;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign addr_a[i]          = rq_addr[i*AW +: AW];
    assign rq_q[i*DW +: DW]   = rq_q_q[i];
  end

  assign pending  = rq_req ^ rq_ack_q;
  assign sdr_done = (sdr_ack == sdr_req_q);

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .pending_i    (pending),
    .last_grant_i (last_grant_q),
    .any_o        (pick_any),
    .grant_o      (pick_g)
  );

  // A same-cycle invalidate forces the miss path so a reloaded ROM is never served stale.
  assign hit = (HIT_BYPASS != 0) && valid_q[pick_g] &&
               (tag_q[pick_g] == addr_a[pick_g]) && !inv;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    sdr_req_d    = sdr_req_q;
    sdr_addr_d   = sdr_addr_q;
    rq_ack_d     = rq_ack_q;
    rq_q_d       = rq_q_q;
    valid_d      = valid_q;
    drop_d       = drop_q;
    tag_d        = tag_q;
    data_d       = data_q;

    case (state_q)
      ARB_SYNC: begin
        if (sdr_done) state_d = ARB_IDLE;
      end
      ARB_IDLE: begin
        if (pick_any) begin
          if (hit) begin
            rq_q_d[pick_g]   = data_q[pick_g];
            rq_ack_d[pick_g] = rq_req[pick_g];
            last_grant_d     = pick_g;
          end else begin
            grant_d    = pick_g;
            sdr_addr_d = addr_a[pick_g];
            sdr_req_d  = ~sdr_req_q;
            state_d    = ARB_WAIT;
          end
        end
      end
      ARB_WAIT: begin
        if (sdr_done) begin
          rq_q_d[grant_q]   = sdr_q;
          rq_ack_d[grant_q] = rq_req[grant_q];
          if (!drop_q) begin
            tag_d[grant_q]   = sdr_addr_q;
            data_d[grant_q]  = sdr_q;
            valid_d[grant_q] = 1'b1;
          end
          last_grant_d = grant_q;
          drop_d       = 1'b0;
          state_d      = ARB_IDLE;
        end else if (inv) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = ARB_SYNC;
    endcase

    if (inv) valid_d = '0;
  end

  always_ff @(posedge CLK_96M) begin
    if (!reset_n) begin
      state_q      <= ARB_SYNC;
      grant_q      <= '0;
      last_grant_q <= IW'(NREQ - 1);
      sdr_req_q    <= 1'b0;
      sdr_addr_q   <= '0;
      rq_ack_q     <= '0;
      valid_q      <= '0;
      drop_q       <= 1'b0;
      for (int i = 0; i < NREQ; i++) rq_q_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      sdr_req_q    <= sdr_req_d;
      sdr_addr_q   <= sdr_addr_d;
      rq_ack_q     <= rq_ack_d;
      valid_q      <= valid_d;
      drop_q       <= drop_d;
      rq_q_q       <= rq_q_d;
    end
  end

  // Tag/data need no reset: nothing reads them until valid is set.
  always_ff @(posedge CLK_96M) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rq_ack   = rq_ack_q;
  assign sdr_req  = sdr_req_q;
  assign sdr_addr = sdr_addr_q;

endmodule
